// File: rtl/if_stage_pkg.sv
// Shared widths and helpers for the instruction-fetch response stage.
// Width helpers describe the packed packets exchanged with pre-IF and ID.
package if_stage_pkg;

  localparam int PcWidth          = 32;
  localparam int InstWidth        = 32;
  localparam int ExceptionTypeLen = 16;
  localparam int CancelWidth      = 2;

  // Action applied to the cancel counter in a given cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  // Packet held from pre-IF: {excep_en, excep_type, pc}; req is consumed at capture.
  function automatic int preif_to_if_w(input int pc_w, input int exc_w);
    return 1 + exc_w + pc_w;
  endfunction

  // Packet to ID: {valid, excep_en, excep_type, pc, inst}.
  function automatic int if_to_id_w(input int pc_w, input int inst_w, input int exc_w);
    return 2 + exc_w + pc_w + inst_w;
  endfunction

  // Feedback to pre-IF: {we, pc}.
  function automatic int if_to_pre_w(input int pc_w);
    return 1 + pc_w;
  endfunction

endpackage

// File: rtl/if_inst_buffer.sv
// One-entry skid register holding an instruction while ID is stalled.
// data_o forwards the live RAM data unless a buffered word is present.
module if_inst_buffer #(
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] ram_data,
  output logic              buf_vld,
  output logic [INST_W-1:0] data_o
);

  logic [INST_W-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld <= 1'b0;
      buf_q   <= '0;
    end else if (clear) begin
      buf_vld <= 1'b0;
    end else if (load) begin
      buf_vld <= 1'b1;
      buf_q   <= ram_data;
    end
  end

  assign data_o = buf_vld ? buf_q : ram_data;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch response stage: pairs each fetch packet with its RAM
// response, skids it while ID stalls and discards responses of flushed fetches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_W     = PcWidth,
  parameter int INST_W   = InstWidth,
  parameter int EXC_W    = ExceptionTypeLen,
  parameter int CANCEL_W = CancelWidth
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prev_to_now_valid_i,
  output logic              now_allowin_o,
  input  logic              prev_req_i,
  input  logic [PC_W-1:0]   prev_pc_i,
  input  logic              prev_excep_en_i,
  input  logic [EXC_W-1:0]  prev_excep_type_i,
  input  logic              excep_flush_i,
  input  logic              inst_ram_data_ok_i,
  input  logic [INST_W-1:0] inst_ram_rdata_i,
  input  logic              next_allowin_i,
  output logic              now_to_next_valid_o,
  output logic [PC_W-1:0]   to_next_pc_o,
  output logic [INST_W-1:0] to_next_inst_o,
  output logic              to_next_excep_en_o,
  output logic [EXC_W-1:0]  to_next_excep_type_o,
  output logic              to_preif_we_o,
  output logic [PC_W-1:0]   to_preif_pc_o
);

  localparam int PktW = preif_to_if_w(PC_W, EXC_W);
  localparam int IdW  = if_to_id_w(PC_W, INST_W, EXC_W);
  localparam int PreW = if_to_pre_w(PC_W);

  logic                valid;
  logic                wait_data;
  logic [PktW-1:0]     pkt;
  logic [CANCEL_W-1:0] cancel_cnt;
  cnt_op_t             cnt_op;

  logic                excep_en;
  logic [EXC_W-1:0]    excep_type;
  logic [PC_W-1:0]     pc;

  logic                cnt_zero;
  logic                data_hit;
  logic                drop;
  logic                ready_go;
  logic                leave;
  logic                capture;
  logic                cancel_req;
  logic                buf_load;
  logic                buf_clear;
  logic                buf_vld;
  logic [INST_W-1:0]   buf_data;

  logic [IdW-1:0]      id_bus;
  logic [PreW-1:0]     pre_bus;

  assign pc         = pkt[PC_W-1:0];
  assign excep_type = pkt[PC_W +: EXC_W];
  assign excep_en   = pkt[PktW-1];

  // A response belongs to the current packet only once every cancelled
  // response ahead of it has drained.
  assign cnt_zero   = (cancel_cnt == '0);
  assign data_hit   = wait_data & inst_ram_data_ok_i & cnt_zero;
  assign drop       = inst_ram_data_ok_i & ~cnt_zero;

  assign ready_go      = valid & (excep_en | buf_vld | data_hit);
  assign leave         = ready_go & next_allowin_i;
  assign now_allowin_o = ~valid | leave;
  assign capture       = prev_to_now_valid_i & now_allowin_o & ~excep_flush_i;
  assign cancel_req    = excep_flush_i & valid & wait_data & ~data_hit;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (cancel_req && !drop) begin
      cnt_op = CNT_INC;
    end else if (drop && !cancel_req) begin
      cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cancel_cnt <= '0;
    end else begin
      case (cnt_op)
        CNT_INC: if (cancel_cnt != '1) cancel_cnt <= cancel_cnt + 1'b1;
        CNT_DEC: cancel_cnt <= cancel_cnt - 1'b1;
        default: cancel_cnt <= cancel_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      wait_data <= 1'b0;
      pkt       <= '0;
    end else if (excep_flush_i) begin
      valid     <= 1'b0;
      wait_data <= 1'b0;
    end else if (capture) begin
      valid     <= 1'b1;
      wait_data <= prev_req_i & ~prev_excep_en_i;
      pkt       <= {prev_excep_en_i, prev_excep_type_i, prev_pc_i};
    end else begin
      if (leave) valid <= 1'b0;
      if (data_hit) wait_data <= 1'b0;
    end
  end

  // Only a response consumed while ID refuses it needs to be skidded.
  assign buf_load  = data_hit & ~next_allowin_i & ~excep_flush_i;
  assign buf_clear = leave | excep_flush_i;

  if_inst_buffer #(
    .INST_W (INST_W)
  ) u_inst_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .ram_data (inst_ram_rdata_i),
    .buf_vld  (buf_vld),
    .data_o   (buf_data)
  );

  assign id_bus = {ready_go & ~excep_flush_i, excep_en, excep_type, pc,
                   excep_en ? {INST_W{1'b0}} : buf_data};

  assign to_next_inst_o       = id_bus[INST_W-1:0];
  assign to_next_pc_o         = id_bus[INST_W +: PC_W];
  assign to_next_excep_type_o = id_bus[INST_W+PC_W +: EXC_W];
  assign to_next_excep_en_o   = id_bus[IdW-2];
  assign now_to_next_valid_o  = id_bus[IdW-1];

  assign pre_bus       = {valid & ~excep_flush_i, pc};
  assign to_preif_pc_o = pre_bus[PC_W-1:0];
  assign to_preif_we_o = pre_bus[PreW-1];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a transaction-level model (held packet plus a
// queue of outstanding RAM responses) is compared every cycle; ID handshakes
// are also matched against hand-computed packets.
module tb_if_stage;

  localparam int W = 1 + 16 + 32 + 32;

  logic        clk;
  logic        rst_n;
  logic        prev_to_now_valid_i;
  logic        now_allowin_o;
  logic        prev_req_i;
  logic [31:0] prev_pc_i;
  logic        prev_excep_en_i;
  logic [15:0] prev_excep_type_i;
  logic        excep_flush_i;
  logic        inst_ram_data_ok_i;
  logic [31:0] inst_ram_rdata_i;
  logic        next_allowin_i;
  logic        now_to_next_valid_o;
  logic [31:0] to_next_pc_o;
  logic [31:0] to_next_inst_o;
  logic        to_next_excep_en_o;
  logic [15:0] to_next_excep_type_o;
  logic        to_preif_we_o;
  logic [31:0] to_preif_pc_o;

  int total;
  int bad;
  logic [W-1:0] exp_q[$];

  if_stage u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .prev_to_now_valid_i  (prev_to_now_valid_i),
    .now_allowin_o        (now_allowin_o),
    .prev_req_i           (prev_req_i),
    .prev_pc_i            (prev_pc_i),
    .prev_excep_en_i      (prev_excep_en_i),
    .prev_excep_type_i    (prev_excep_type_i),
    .excep_flush_i        (excep_flush_i),
    .inst_ram_data_ok_i   (inst_ram_data_ok_i),
    .inst_ram_rdata_i     (inst_ram_rdata_i),
    .next_allowin_i       (next_allowin_i),
    .now_to_next_valid_o  (now_to_next_valid_o),
    .to_next_pc_o         (to_next_pc_o),
    .to_next_inst_o       (to_next_inst_o),
    .to_next_excep_en_o   (to_next_excep_en_o),
    .to_next_excep_type_o (to_next_excep_type_o),
    .to_preif_we_o        (to_preif_we_o),
    .to_preif_pc_o        (to_preif_pc_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic pv, input logic req, input logic [31:0] pc,
                        input logic exc, input logic [15:0] et, input logic fl,
                        input logic dok, input logic [31:0] rd, input logic nal);
    prev_to_now_valid_i = pv;
    prev_req_i          = req;
    prev_pc_i           = pc;
    prev_excep_en_i     = exc;
    prev_excep_type_i   = et;
    excep_flush_i       = fl;
    inst_ram_data_ok_i  = dok;
    inst_ram_rdata_i    = rd;
    next_allowin_i      = nal;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_id(input logic [31:0] pc, input logic [31:0] inst,
                           input logic exc, input logic [15:0] et);
    exp_q.push_back({exc, et, pc, inst});
  endtask

  // behavioural model: the packet currently held and the responses still owed
  // by the RAM, each tagged live (1) or cancelled (0), oldest first
  bit          m_fifo[$];
  logic        m_hold, m_need, m_has, m_exc;
  logic [31:0] m_pc, m_inst;
  logic [15:0] m_type;

  always @(negedge clk) begin
    logic deliver, allow, leave, front_live;
    logic [31:0] exp_inst;
    logic [W-1:0] e;
    if (!rst_n) begin
      m_hold = 1'b0; m_need = 1'b0; m_has = 1'b0; m_exc = 1'b0;
      m_pc = '0; m_inst = '0; m_type = '0;
      m_fifo.delete();
    end else begin
      front_live = (m_fifo.size() > 0) && m_fifo[0];
      deliver = m_hold && (m_exc || m_has || (m_need && inst_ram_data_ok_i && front_live));
      allow   = !m_hold || (deliver && next_allowin_i);
      leave   = deliver && next_allowin_i && !excep_flush_i;
      exp_inst = m_exc ? 32'h0 : (m_has ? m_inst : inst_ram_rdata_i);

      check("out_valid", now_to_next_valid_o, deliver && !excep_flush_i);
      check("allowin", now_allowin_o, allow);
      check("preif_we", to_preif_we_o, m_hold && !excep_flush_i);
      if (m_hold) check("preif_pc", to_preif_pc_o, m_pc);
      if (deliver && !excep_flush_i) begin
        check("id_pc", to_next_pc_o, m_pc);
        check("id_inst", to_next_inst_o, exp_inst);
        check("id_exc", to_next_excep_en_o, m_exc);
        check("id_type", to_next_excep_type_o, m_type);
      end

      // scoreboard of hand-computed ID packets
      if (now_to_next_valid_o === 1'b1 && next_allowin_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_packet", {to_next_excep_en_o, to_next_excep_type_o, to_next_pc_o, to_next_inst_o}, e);
        end
      end

      if (inst_ram_data_ok_i && m_fifo.size() > 0) begin
        if (m_fifo.pop_front() && m_hold && m_need) begin
          m_need = 1'b0;
          m_has  = 1'b1;
          m_inst = inst_ram_rdata_i;
        end
      end
      if (excep_flush_i) begin
        m_hold = 1'b0;
        foreach (m_fifo[i]) m_fifo[i] = 1'b0;
      end else begin
        if (leave) m_hold = 1'b0;
        if (prev_to_now_valid_i && allow) begin
          m_hold = 1'b1;
          m_pc   = prev_pc_i;
          m_exc  = prev_excep_en_i;
          m_type = prev_excep_type_i;
          m_need = prev_req_i && !prev_excep_en_i;
          m_has  = 1'b0;
          if (m_need) m_fifo.push_back(1'b1);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    #1;
    check("rst_valid", now_to_next_valid_o, 1'b0);
    check("rst_we", to_preif_we_o, 1'b0);
    check("rst_allowin", now_allowin_o, 1'b1);
    check("rst_pc", to_preif_pc_o, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // normal fetch
    set_in(1, 1, 32'h1C000000, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'h02800C0C, 1);
    expect_id(32'h1C000000, 32'h02800C0C, 1'b0, 16'h0);
    #1;
    check("norm_preif_pc", to_preif_pc_o, 32'h1C000000);
    check("norm_inst", to_next_inst_o, 32'h02800C0C);
    tick();
    idle(); tick();

    // ID stall, then release from the skid buffer
    set_in(1, 1, 32'h1C000004, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'h12345678, 0); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 0, 32'h0, 0);
    #1;
    check("stall_allowin", now_allowin_o, 1'b0);
    check("stall_inst", to_next_inst_o, 32'h12345678);
    tick(); tick();
    idle();
    expect_id(32'h1C000004, 32'h12345678, 1'b0, 16'h0);
    tick();
    idle(); tick();

    // flush while the response is still in flight
    set_in(1, 1, 32'h1C000008, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 1, 0, 32'h0, 1); tick();
    set_in(1, 1, 32'h1C000010, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'hDEADBEEF, 1);
    #1;
    check("drop_valid", now_to_next_valid_o, 1'b0);
    tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'h00000001, 1);
    expect_id(32'h1C000010, 32'h00000001, 1'b0, 16'h0);
    tick();
    idle(); tick();

    // exception packet needs no response
    set_in(1, 0, 32'h1C000020, 1, 16'h0001, 0, 0, 32'h0, 1); tick();
    idle();
    expect_id(32'h1C000020, 32'h0, 1'b1, 16'h0001);
    #1;
    check("exc_valid", now_to_next_valid_o, 1'b1);
    check("exc_inst", to_next_inst_o, 32'h0);
    tick();

    // back-to-back at full throughput
    set_in(1, 1, 32'h1C000000, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(1, 1, 32'h1C000004, 0, 16'h0, 0, 1, 32'hAAAA0001, 1);
    expect_id(32'h1C000000, 32'hAAAA0001, 1'b0, 16'h0);
    #1; check("b2b_allowin0", now_allowin_o, 1'b1);
    tick();
    set_in(1, 1, 32'h1C000008, 0, 16'h0, 0, 1, 32'hAAAA0002, 1);
    expect_id(32'h1C000004, 32'hAAAA0002, 1'b0, 16'h0);
    #1; check("b2b_allowin1", now_allowin_o, 1'b1);
    tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'hAAAA0003, 1);
    expect_id(32'h1C000008, 32'hAAAA0003, 1'b0, 16'h0);
    tick();
    idle(); tick();

    // two cancelled responses outstanding plus a waiting packet, then reset
    set_in(1, 1, 32'h1C000100, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 1, 0, 32'h0, 1); tick();
    set_in(1, 1, 32'h1C000104, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 1, 0, 32'h0, 1); tick();
    set_in(1, 1, 32'h1C000108, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    idle();
    #1;
    check("pre_rst_we", to_preif_we_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", now_to_next_valid_o, 1'b0);
    check("arst_we", to_preif_we_o, 1'b0);
    check("arst_allowin", now_allowin_o, 1'b1);
    check("arst_pc", to_preif_pc_o, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    set_in(1, 1, 32'h1C000040, 0, 16'h0, 0, 0, 32'h0, 1); tick();
    set_in(0, 0, 32'h0, 0, 16'h0, 0, 1, 32'hCAFEF00D, 1);
    expect_id(32'h1C000040, 32'hCAFEF00D, 1'b0, 16'h0);
    tick();
    idle(); tick(); tick();

    // final report
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
